// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Memory-side bus controller sitting directly downstream of the
//               register managers. It accepts one-cycle read/write strobes,
//               performs the access on a synchronous RAM port, and then
//               broadcasts the completion (address plus data) for one cycle,
//               so that every register manager can match its own address.
//               While an access is in flight, one further request can wait in
//               a one-deep pending buffer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro : MEMBUS_TIMEOUT_EN
//   defined   - an access that gets no mem_ack within TIMEOUT cycles is
//               completed with bus_data = 0 and bus_err = 1
//   undefined - the controller waits indefinitely for mem_ack and bus_err
//               is tied to 0
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  maximum number of REQ/WAIT cycles before a timeout completion
//            (used only when MEMBUS_TIMEOUT_EN is defined)
// Ports
//   clk, rst              clock; synchronous active-high reset
//   read_q, write_q       one-cycle request strobes (write wins if both set)
//   req_addr, req_wdata   request address / write data, valid with strobe
//   is_bus_busy           completion broadcast valid (one cycle)
//   read_dn, write_dn     completion kind, valid with is_bus_busy
//   bus_addr, bus_data    serviced address and read data / echoed write data
//   mem_en, mem_we        RAM access enable / write enable
//   mem_addr, mem_wdata   RAM address / write data
//   mem_ack, mem_rdata    RAM access done; read data valid in the same cycle
//   overrun               sticky: a request was lost
//   bus_err               the completion was caused by a timeout
// ============================================================================
module mem_bus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    // requester side
    input  logic              read_q,
    input  logic              write_q,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // completion broadcast
    output logic              is_bus_busy,
    output logic              read_dn,
    output logic              write_dn,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    // RAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              overrun,
    output logic              bus_err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,  // waiting for a request
        S_REQ  = 3'd1,  // first cycle of the RAM access
        S_WAIT = 3'd2,  // access still outstanding, waiting for mem_ack
        S_DONE = 3'd3,  // one-cycle completion broadcast
        S_GAP  = 3'd4   // one quiet cycle between completions
    } state_t;

    state_t              r_state;

    // Latched copy of the request being serviced.
    logic                r_op_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    // One-deep pending buffer.
    logic                r_pend_vld;
    logic                r_pend_we;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic [DATA_W-1:0]   r_pend_wdata;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic                w_strobe;
    logic                w_both;
    logic                w_idle;
    logic                w_start_pend;
    logic                w_start_new;
    logic                w_start;
    logic                w_buf_load;
    logic                w_drop;
    logic                w_set_overrun;
    logic                w_src_we;
    logic [ADDR_W-1:0]   w_src_addr;
    logic [DATA_W-1:0]   w_src_wdata;

    assign w_strobe     = read_q | write_q;
    // Both strobes together: the write is kept and the read is lost.
    assign w_both       = read_q & write_q;
    assign w_idle       = (r_state == S_IDLE);

    // In IDLE the buffered request is older, so it is serviced before a new
    // strobe arriving in the same cycle.
    assign w_start_pend = w_idle & r_pend_vld;
    assign w_start_new  = w_idle & ~r_pend_vld & w_strobe;
    assign w_start      = w_start_pend | w_start_new;

    // A strobe lands in the buffer when the controller is busy and the buffer
    // is free, or when the buffer is being emptied in this very cycle.
    assign w_buf_load   = w_strobe & ((~w_idle & ~r_pend_vld) | w_start_pend);
    assign w_drop       = w_strobe & ~w_idle & r_pend_vld;
    assign w_set_overrun = w_drop | w_both;

    // Source of the access that starts in IDLE.
    assign w_src_we     = w_start_pend ? r_pend_we    : write_q;
    assign w_src_addr   = w_start_pend ? r_pend_addr  : req_addr;
    assign w_src_wdata  = w_start_pend ? r_pend_wdata : req_wdata;

    // ------------------------------------------------------------------------
    // Access termination
    // ------------------------------------------------------------------------
    logic                w_in_access;
    logic                w_timeout;
    logic                w_finish;
    logic                w_timed_out;

    assign w_in_access  = (r_state == S_REQ) || (r_state == S_WAIT);

`ifdef MEMBUS_TIMEOUT_EN
    // At least 8 bits wide, wider if TIMEOUT needs it.
    localparam int c_CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [c_CNT_W-1:0]  r_cnt;

    // The counter holds the number of REQ/WAIT cycles already spent, so the
    // TIMEOUT-th cycle is the one where it reads TIMEOUT-1.
    assign w_timeout    = w_in_access && (r_cnt == c_CNT_W'(TIMEOUT - 1));
`else
    logic                w_timeout_unused;

    assign w_timeout        = 1'b0;
    assign w_timeout_unused = (TIMEOUT == 0);
    assign bus_err          = 1'b0;
`endif

    // A mem_ack in the timeout cycle wins and gives a normal completion.
    assign w_finish     = w_in_access & (mem_ack | w_timeout);
    assign w_timed_out  = w_in_access & ~mem_ack & w_timeout;

    // ------------------------------------------------------------------------
    // Controller FSM, pending buffer and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op_we      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_pend_vld   <= 1'b0;
            r_pend_we    <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_wdata <= '0;
            is_bus_busy  <= 1'b0;
            read_dn      <= 1'b0;
            write_dn     <= 1'b0;
            bus_addr     <= '0;
            bus_data     <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            overrun      <= 1'b0;
`ifdef MEMBUS_TIMEOUT_EN
            r_cnt        <= '0;
            bus_err      <= 1'b0;
`endif
        end else begin
            // Sticky loss indicator; cleared only by reset.
            if (w_set_overrun) begin
                overrun <= 1'b1;
            end

            // Pending buffer: load takes priority over the plain drain so a
            // strobe in the consuming cycle refills it.
            if (w_buf_load) begin
                r_pend_vld   <= 1'b1;
                r_pend_we    <= write_q;
                r_pend_addr  <= req_addr;
                r_pend_wdata <= req_wdata;
            end else if (w_start_pend) begin
                r_pend_vld   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_REQ;
                        r_op_we   <= w_src_we;
                        r_addr    <= w_src_addr;
                        r_wdata   <= w_src_wdata;
                        // RAM port is driven straight from the latch values
                        // and then held until the access ends.
                        mem_en    <= 1'b1;
                        mem_we    <= w_src_we;
                        mem_addr  <= w_src_addr;
                        mem_wdata <= w_src_wdata;
`ifdef MEMBUS_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end
                end

                S_REQ, S_WAIT: begin
                    if (w_finish) begin
                        r_state     <= S_DONE;
                        mem_en      <= 1'b0;
                        mem_we      <= 1'b0;
                        mem_addr    <= '0;
                        mem_wdata   <= '0;
                        is_bus_busy <= 1'b1;
                        read_dn     <= ~r_op_we;
                        write_dn    <= r_op_we;
                        bus_addr    <= r_addr;
                        // Read data is captured in the mem_ack cycle; writes
                        // echo the data that was written.
                        if (w_timed_out) begin
                            bus_data <= '0;
                        end else if (r_op_we) begin
                            bus_data <= r_wdata;
                        end else begin
                            bus_data <= mem_rdata;
                        end
`ifdef MEMBUS_TIMEOUT_EN
                        bus_err     <= w_timed_out;
`endif
                    end else begin
                        r_state <= S_WAIT;
`ifdef MEMBUS_TIMEOUT_EN
                        r_cnt   <= r_cnt + c_CNT_W'(1);
`endif
                    end
                end

                S_DONE: begin
                    // Completion is broadcast for exactly one cycle.
                    r_state     <= S_GAP;
                    is_bus_busy <= 1'b0;
                    read_dn     <= 1'b0;
                    write_dn    <= 1'b0;
                    bus_addr    <= '0;
                    bus_data    <= '0;
`ifdef MEMBUS_TIMEOUT_EN
                    bus_err     <= 1'b0;
`endif
                end

                S_GAP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
